// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer.
// Evaluates one WIDTH-bit ALU operation by stepping a single 1-bit ALU slice
// across the operands, LSB first, one bit per clock. The control encoding and
// the flags match the parallel ripple ALU it sits beside:
//   ALU_control_i = {Ainvert, Binvert, operation[1:0]}
//   operation 00=AND, 01=SLT, 10=OR, 11=ADD (SUB = ADD with Binvert set)
// The result and flags are registered. They only change in the DONE cycle, so
// no partial result is ever visible on the outputs.
module alu_serial_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ALU_control_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SLT_FIX,
        S_DONE
    } state_e;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_SLT = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Sequencer state and the operand/result shift registers
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   r_sh_q, r_sh_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Values captured in the MSB cycle, needed for SLT and the flags
    logic               c_msb_in_q, c_msb_in_d;
    logic               c_out_q, c_out_d;
    logic               s_msb_q, s_msb_d;

    // Registered outputs
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    // 1-bit ALU slice signals
    logic               slice_a;
    logic               slice_b;
    logic [1:0]         slice_op;
    logic               slice_sum;
    logic               slice_cout;
    logic               slice_out;
    logic               last_bit;

    assign last_bit = (cnt_q == LAST_BIT);

    // One-bit ALU slice: operand inversion, full adder and the operation mux
    always_comb begin
        slice_a    = a_sh_q[0] ^ ctrl_q[3];
        slice_b    = b_sh_q[0] ^ ctrl_q[2];
        // SLT runs the slice as an adder so the subtraction is produced;
        // the actual less-than bit is formed afterwards in SLT_FIX.
        slice_op   = (ctrl_q[1:0] == OP_SLT) ? OP_ADD : ctrl_q[1:0];
        slice_sum  = slice_a ^ slice_b ^ carry_q;
        slice_cout = (slice_a & slice_b) | (slice_a & carry_q) | (slice_b & carry_q);
        // NOTE: every signal assigned in a combinational block needs a value
        // on every path, otherwise synthesis infers a latch; the default arm
        // below (Less input, tied to 0) closes the case.
        case (slice_op)
            OP_AND:  slice_out = slice_a & slice_b;
            OP_OR:   slice_out = slice_a | slice_b;
            OP_ADD:  slice_out = slice_sum;
            default: slice_out = 1'b0;
        endcase
    end

    // Next-state and datapath update for the sequencer
    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        r_sh_d     = r_sh_q;
        ctrl_d     = ctrl_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        c_msb_in_d = c_msb_in_q;
        c_out_d    = c_out_q;
        s_msb_d    = s_msb_q;
        result_d   = result_q;
        zero_d     = zero_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_sh_d  = src1_i;
                    b_sh_d  = src2_i;
                    ctrl_d  = ALU_control_i;
                    // Carry chain is re-seeded every operation: Binvert
                    // supplies the +1 of the two's-complement subtract.
                    carry_d = ALU_control_i[2];
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                r_sh_d  = {slice_out, r_sh_q[WIDTH-1:1]};
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = slice_cout;
                cnt_d   = cnt_q + 1'b1;
                if (last_bit) begin
                    c_msb_in_d = carry_q;
                    c_out_d    = slice_cout;
                    s_msb_d    = slice_sum;
                    state_d    = (ctrl_q[1:0] == OP_SLT) ? S_SLT_FIX : S_DONE;
                end
            end

            S_SLT_FIX: begin
                // Signed less-than: sign of the difference corrected by overflow
                r_sh_d  = {{(WIDTH-1){1'b0}}, s_msb_q ^ (c_msb_in_q ^ c_out_q)};
                state_d = S_DONE;
            end

            S_DONE: begin
                result_d = r_sh_q;
                zero_d   = (r_sh_q == '0);
                if (ctrl_q[1:0] == OP_ADD) begin
                    cout_d = c_out_q;
                    ovf_d  = c_msb_in_q ^ c_out_q;
                end else begin
                    cout_d = 1'b0;
                    ovf_d  = 1'b0;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything, aborting any run
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            r_sh_q     <= '0;
            ctrl_q     <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            c_msb_in_q <= 1'b0;
            c_out_q    <= 1'b0;
            s_msb_q    <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, so ordering inside this block does not matter.
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            r_sh_q     <= r_sh_d;
            ctrl_q     <= ctrl_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            c_msb_in_q <= c_msb_in_d;
            c_out_q    <= c_out_d;
            s_msb_q    <= s_msb_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;
    assign done_o     = done_q;
    // Busy covers RUN, SLT_FIX and DONE; it drops as done_o rises.
    assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq (WIDTH=32): directed vector table,
// handshake/reset sequences, and randomized operations against a word-level
// reference model.
module tb_alu_serial_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst_i;
    logic         start_i;
    logic [3:0]   ALU_control_i;
    logic [W-1:0] src1_i;
    logic [W-1:0] src2_i;
    logic [W-1:0] result_o;
    logic         zero_o;
    logic         cout_o;
    logic         overflow_o;
    logic         busy_o;
    logic         done_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] result;
        logic         zero;
        logic         cout;
        logic         ovf;
        int           lat;
    } exp_t;

    typedef struct {
        string        name;
        logic [3:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         exp;
    } vec_t;

    vec_t vq[$];

    alu_serial_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .ALU_control_i(ALU_control_i),
        .src1_i       (src1_i),
        .src2_i       (src2_i),
        .result_o     (result_o),
        .zero_o       (zero_o),
        .cout_o       (cout_o),
        .overflow_o   (overflow_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Word-level reference: whole-operand arithmetic on the inverted operands
    function automatic exp_t model(input logic [3:0] ctrl, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t         e;
        logic [W-1:0] ai, bi;
        logic [W:0]   sum;
        logic         ovf;
        ai  = ctrl[3] ? ~a : a;
        bi  = ctrl[2] ? ~b : b;
        sum = {1'b0, ai} + {1'b0, bi} + (W+1)'(ctrl[2]);
        ovf = (ai[W-1] == bi[W-1]) && (sum[W-1] != ai[W-1]);
        case (ctrl[1:0])
            2'b00:   e.result = ai & bi;
            2'b10:   e.result = ai | bi;
            2'b11:   e.result = sum[W-1:0];
            default: e.result = {{(W-1){1'b0}}, sum[W-1] ^ ovf};
        endcase
        e.zero = (e.result == '0);
        e.cout = (ctrl[1:0] == 2'b11) ? sum[W] : 1'b0;
        e.ovf  = (ctrl[1:0] == 2'b11) ? ovf : 1'b0;
        e.lat  = (ctrl[1:0] == 2'b01) ? W + 2 : W + 1;
        return e;
    endfunction

    task automatic add_vec(input string name, input logic [3:0] ctrl, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] r, input logic z,
                           input logic c, input logic v, input int lat);
        vec_t t;
        t.name = name; t.ctrl = ctrl; t.a = a; t.b = b;
        t.exp.result = r; t.exp.zero = z; t.exp.cout = c; t.exp.ovf = v; t.exp.lat = lat;
        vq.push_back(t);
    endtask

    // Runs one operation from a negedge and checks it; with noise set, inputs
    // and start_i are scrambled while busy to show they are ignored.
    task automatic do_op(input string tag, input logic [3:0] ctrl, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit noise, input exp_t exp);
        logic [W-1:0] prev;
        int           lat;
        bit           busy_ok, hold_ok, was_done;
        prev    = result_o;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        ALU_control_i = ctrl; src1_i = a; src2_i = b; start_i = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        start_i = 1'b0;
        while (!done_o && lat < 100) begin
            if (!busy_o) busy_ok = 1'b0;
            if (result_o !== prev) hold_ok = 1'b0;
            if (noise) begin
                start_i       = 1'($urandom_range(0, 1));
                src1_i        = $urandom;
                src2_i        = $urandom;
                ALU_control_i = 4'($urandom_range(0, 15));
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start_i  = 1'b0;
        was_done = done_o;
        check({tag, " done_seen"}, 64'(was_done), 64'(1));
        check({tag, " latency"},   64'(lat), 64'(exp.lat));
        check({tag, " result"},    64'(result_o), 64'(exp.result));
        check({tag, " zero"},      64'(zero_o), 64'(exp.zero));
        check({tag, " cout"},      64'(cout_o), 64'(exp.cout));
        check({tag, " overflow"},  64'(overflow_o), 64'(exp.ovf));
        check({tag, " busy_during_run_and_low_at_done"}, 64'(busy_ok && !busy_o), 64'(1));
        check({tag, " output_hold"}, 64'(hold_ok), 64'(1));
        @(posedge clk);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 64'(done_o), 64'(0));
        check({tag, " result_held"},    64'(result_o), 64'(exp.result));
    endtask

    initial begin
        exp_t e;
        int   dones, first_i, second_i;
        logic [W-1:0] corner [5];

        rst_i = 1'b1; start_i = 1'b0; ALU_control_i = '0; src1_i = '0; src2_i = '0;
        repeat (2) @(negedge clk);
        check("reset result",   64'(result_o), 64'(0));
        check("reset flags",    64'({zero_o, cout_o, overflow_o}), 64'(0));
        check("reset busy_done", 64'({busy_o, done_o}), 64'(0));
        rst_i = 1'b0;
        @(negedge clk);

        // Directed vectors with hand-derived expectations
        add_vec("add_ovf",  4'b0011, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 33);
        add_vec("sub_eq",   4'b0111, 32'd5,         32'd5,         32'h0000_0000, 1, 1, 0, 33);
        add_vec("slt_lt",   4'b0101, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0001, 0, 0, 0, 34);
        add_vec("slt_ge",   4'b0101, 32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0000, 1, 0, 0, 34);
        add_vec("slt_ovf",  4'b0101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0, 34);
        add_vec("nor",      4'b1100, 32'hF0F0_F0F0, 32'h0F0F_0F00, 32'h0000_000F, 0, 0, 0, 33);
        add_vec("and",      4'b0000, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 0, 0, 0, 33);
        add_vec("or",       4'b0010, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 0, 0, 0, 33);
        add_vec("nand_all", 4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0, 33);
        add_vec("sub_ovf",  4'b0111, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1, 1, 33);
        add_vec("add_wrap", 4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1, 0, 33);
        foreach (vq[i]) do_op(vq[i].name, vq[i].ctrl, vq[i].a, vq[i].b, 1'b0, vq[i].exp);

        // start_i held high for 40 cycles: one done in that window, then a
        // second operation accepted on the cycle after DONE.
        ALU_control_i = 4'b0011; src1_i = 32'd100; src2_i = 32'd23; start_i = 1'b1;
        dones = 0; first_i = -1; second_i = -1;
        for (int i = 0; i < 140 && second_i < 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_o) begin
                if (first_i < 0) begin
                    first_i = i;
                    check("held first result", 64'(result_o), 64'(123));
                    src1_i = 32'd10; src2_i = 32'd20;
                end else begin
                    second_i = i;
                end
                if (i < 40) dones++;
            end
            if (i == 39) start_i = 1'b0;
        end
        start_i = 1'b0;
        check("held dones_in_window", 64'(dones), 64'(1));
        check("held first_latency", 64'(first_i), 64'(33));
        check("held second_gap", 64'(second_i - first_i), 64'(34));
        check("held second_result", 64'(result_o), 64'(30));
        repeat (2) @(negedge clk);

        // Reset in the middle of an ADD: outputs clear at once, no done follows
        e = model(4'b0011, 32'h7FFF_FFFF, 32'h1);
        do_op("pre_abort", 4'b0011, 32'h7FFF_FFFF, 32'h1, 1'b0, e);
        ALU_control_i = 4'b0011; src1_i = 32'h1234; src2_i = 32'h1; start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check("abort result", 64'(result_o), 64'(0));
        check("abort flags", 64'({zero_o, cout_o, overflow_o}), 64'(0));
        check("abort busy_done", 64'({busy_o, done_o}), 64'(0));
        @(negedge clk);
        rst_i = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        check("abort no_done", 64'(dones), 64'(0));
        e = model(4'b0011, 32'd1, 32'd2);
        do_op("post_abort", 4'b0011, 32'd1, 32'd2, 1'b0, e);

        // Randomized operations against the reference model
        corner = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};
        for (int n = 0; n < 40; n++) begin
            logic [3:0]   c;
            logic [W-1:0] a, b;
            c = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            e = model(c, a, b);
            do_op($sformatf("rand%0d ctrl=%b", n, c), c, a, b, 1'b1, e);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Bit-serial ALU sequencer: evaluates one WIDTH-bit ALU operation by stepping a single 1-bit ALU slice over the operands, one bit per clock, LSB first.
- Holds operands, the carry chain and the result in internal registers. Owns the start/busy/done handshake.
- Used as the area-minimal ALU alternative beside the parallel ripple ALU. Same control encoding, same flags.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request pulse; sampled only in IDLE.
- ALU_control_i  in  4  {Ainvert, Binvert, operation[1:0]}; operation 00=AND, 01=SLT, 10=OR, 11=ADD.
- src1_i  in  WIDTH  operand A.
- src2_i  in  WIDTH  operand B.
- result_o  out  WIDTH  registered result.
- zero_o  out  1  result_o == 0.
- cout_o  out  1  carry out of MSB. Valid for ADD/SUB; 0 otherwise.
- overflow_o  out  1  signed overflow. Valid for ADD/SUB; 0 otherwise.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse; outputs are valid from this cycle.

Behaviour:
- Reset (asynchronous, any state, including mid-run): state=IDLE; result_o=0, zero_o=0, cout_o=0, overflow_o=0, busy_o=0, done_o=0; internal shift registers, carry and counter cleared. An aborted operation produces no done_o.
- States: IDLE, RUN, SLT_FIX, DONE.
- IDLE:
  - On start_i=1, capture src1_i, src2_i and ALU_control_i into A_sh, B_sh and ctrl.
  - Set carry = Binvert, cnt = 0, go to RUN.
  - Input changes after capture have no effect.
- RUN, one bit per cycle:
  - Slice inputs: a=A_sh[0], b=B_sh[0], CarryIn=carry, Less=0.
  - Slice operation: ctrl operation, except SLT, which drives 11 so the subtract is computed.
  - Slice output is shifted into the MSB of the result shift register. A_sh and B_sh shift right. carry <= slice CarryOut.
  - At cnt==WIDTH-1 (MSB cycle):
    - Record c_msb_in = carry.
    - Record c_out = slice CarryOut.
    - Record s_msb = slice sum.
  - Then cnt increments. After WIDTH RUN cycles, go to SLT_FIX if operation==01, else DONE.
- SLT_FIX (one cycle): result register = {WIDTH-1 zeros, s_msb ^ (c_msb_in ^ c_out)}, i.e. signed a<b after Ainvert/Binvert are applied.
- DONE (one cycle):
  - done_o=1; result_o loaded; zero_o = (result==0).
  - For operation 11: cout_o = c_out, overflow_o = c_msb_in ^ c_out. For other operations both flags are 0.
  - Next state IDLE. busy_o falls in this cycle.
- Latency, start accepted edge to done_o high: WIDTH+1 cycles for AND/OR/ADD; WIDTH+2 cycles for SLT.
- Back-to-back: earliest next start_i is sampled the cycle after DONE.
- start_i asserted while busy or in DONE is ignored; it is not queued.
- Output hold: result_o and flags hold their values until the next DONE. They never show partial results.
- Encodings used by the bench:
  - AND 0000, OR 0010, ADD 0011, SUB 0111, SLT 0111 with op=01, i.e. 0101 plus Binvert = 0101|0100 = 0101.
  - NOR 1100, NAND 1110.
- Carry chain: no carry between operations; it is re-seeded with Binvert at every start.

Test Plan:
- Reset, then ADD 0x7FFFFFFF + 0x00000001 -> done_o exactly 33 cycles after start. result_o = 0x80000000, overflow_o=1, cout_o=0, zero_o=0.
- SUB (0111) 5 - 5 -> result_o = 0, zero_o=1, cout_o=1, overflow_o=0.
- SLT (0101), src1 = 0xFFFFFFFE (-2), src2 = 0x00000003 -> done_o 34 cycles after start, result_o = 1. Swapped operands -> result_o = 0.
- SLT with 0x80000000 vs 0x7FFFFFFF (overflow case) -> result_o = 1.
- NOR (1100) on 0xF0F0F0F0 and 0x0F0F0F00 -> result_o = 0x0000000F, cout_o=0, overflow_o=0.
- Handshake and reset:
  - start_i held high for 40 cycles -> exactly one done_o pulse, then a second operation starts on the cycle after DONE.
  - rst_i asserted at cnt=10 of an ADD -> all outputs 0 immediately, no done_o, next start runs cleanly.
